// File: rtl/acc_alu_sequencer.sv
// acc_alu_sequencer: accumulator sequencer driving an external 8-bit ALU for LDA/ADD/SUB/MUL/CLR commands
// Ports: clk_in/rst_in clock and sync active-high reset; cmd_* valid/ready command channel;
// alu_a_out/alu_b_out/alu_ctrl_out drive the external ALU, alu_sum_in/alu_carry_in/alu_ovf_in return its result;
// acc_out and carry/ovf/zero flags are registered; done_out/err_out pulse one cycle on completion.
module acc_alu_sequencer #(
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter logic [2:0] ALU_SUB = 3'b011
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       cmd_valid_in,
  output logic       cmd_ready_out,
  input  logic [2:0] cmd_op_in,
  input  logic [7:0] cmd_data_in,
  output logic [7:0] alu_a_out,
  output logic [7:0] alu_b_out,
  output logic [2:0] alu_ctrl_out,
  input  logic [7:0] alu_sum_in,
  input  logic       alu_carry_in,
  input  logic       alu_ovf_in,
  output logic [7:0] acc_out,
  output logic       carry_flag_out,
  output logic       ovf_flag_out,
  output logic       zero_flag_out,
  output logic       done_out,
  output logic       err_out
);
  localparam logic [2:0] OP_LDA = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011, OP_MUL = 3'b100, OP_CLR = 3'b101;
  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d, cnt_q, cnt_d;
  logic [7:0] data_q, data_d, acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d, prod_nx;
  logic c_q, c_d, v_q, v_d, z_q, z_d, done_q, done_d, err_q, err_d;
  logic accept, arith, mul_last;
  assign cmd_ready_out = (state_q == IDLE) && !rst_in;
  assign accept = cmd_valid_in && cmd_ready_out;
  assign arith = (state_q == EXEC) && (op_q == OP_ADD || op_q == OP_SUB);
  assign mul_last = (state_q == MUL) && (cnt_q == 3'd7);
  // partial product accumulates only when the current multiplier bit is set
  assign prod_nx = mplier_q[0] ? alu_sum_in : prod_q;
  assign alu_a_out = (state_q == MUL) ? prod_q : arith ? acc_q : 8'h00;
  assign alu_b_out = (state_q == MUL) ? mcand_q : arith ? data_q : 8'h00;
  assign alu_ctrl_out = (arith && op_q == OP_SUB) ? ALU_SUB : ALU_ADD;
  assign acc_out = acc_q;
  assign carry_flag_out = c_q;
  assign ovf_flag_out = v_q;
  assign zero_flag_out = z_q;
  assign done_out = done_q;
  assign err_out = err_q;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    data_d = data_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    prod_d = prod_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    c_d = c_q;
    v_d = v_q;
    z_d = z_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        op_d = cmd_op_in;
        data_d = cmd_data_in;
        state_d = (cmd_op_in == OP_MUL) ? MUL : EXEC;
        if (cmd_op_in == OP_MUL) begin
          mcand_d = acc_q;
          mplier_d = cmd_data_in;
          prod_d = 8'h00;
          cnt_d = 3'd0;
        end
      end
      EXEC: begin
        state_d = IDLE;
        done_d = 1'b1;
        err_d = (op_q[2:1] == 2'b11);
        case (op_q)
          OP_ADD, OP_SUB: {acc_d, c_d, v_d, z_d} = {alu_sum_in, alu_carry_in, alu_ovf_in, alu_sum_in == 8'h00};
          OP_LDA: {acc_d, c_d, v_d, z_d} = {data_q, 2'b00, data_q == 8'h00};
          OP_CLR: {acc_d, c_d, v_d, z_d} = {8'h00, 3'b001};
          default: ;
        endcase
      end
      MUL: begin
        prod_d = prod_nx;
        mcand_d = {mcand_q[6:0], 1'b0};
        mplier_d = {1'b0, mplier_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        if (mul_last) begin
          state_d = IDLE;
          done_d = 1'b1;
          {acc_d, c_d, v_d, z_d} = {prod_nx, 2'b00, prod_nx == 8'h00};
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      op_q <= 3'd0;
      data_q <= 8'h00;
      mcand_q <= 8'h00;
      mplier_q <= 8'h00;
      prod_q <= 8'h00;
      cnt_q <= 3'd0;
      acc_q <= 8'h00;
      c_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      data_q <= data_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      prod_q <= prod_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      c_q <= c_d;
      v_q <= v_d;
      z_q <= z_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/acc_alu_sequencer.md
ACC_ALU_SEQUENCER -- requirements
Module: acc_alu_sequencer

Interface
REQ-001 SHALL have parameter ALU_ADD, default 3'b010, the ALU control code for A+B, with bit 0 = 0 (carry-in 0).
REQ-002 SHALL have parameter ALU_SUB, default 3'b011, the ALU control code for A-B, with bit 0 = 1 (carry-in 1).
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid_in, input, 1 bit: command present.
REQ-006 SHALL have port cmd_ready_out, output, 1 bit: sequencer can accept a command.
REQ-007 SHALL have port cmd_op_in, input, 3 bits: opcode; 000 NOP, 001 LDA, 010 ADD, 011 SUB, 100 MUL, 101 CLR, 110/111 illegal.
REQ-008 SHALL have port cmd_data_in, input, 8 bits: operand.
REQ-009 SHALL have ports alu_a_out and alu_b_out, outputs, 8 bits each: ALU operands.
REQ-010 SHALL have port alu_ctrl_out, output, 3 bits: ALU control.
REQ-011 SHALL have port alu_sum_in, input, 8 bits, and ports alu_carry_in and alu_ovf_in, inputs, 1 bit each: ALU results.
REQ-012 SHALL have port acc_out, output, 8 bits: accumulator.
REQ-013 SHALL have ports carry_flag_out, ovf_flag_out and zero_flag_out, outputs, 1 bit each: registered flags.
REQ-014 SHALL have ports done_out and err_out, outputs, 1 bit each: single-cycle completion and illegal-op pulses.

Function
REQ-015 SHALL implement the state machine IDLE, EXEC, MUL; cmd_ready_out = 1 only in IDLE with rst_in low.
REQ-016 SHALL treat a command as accepted on a rising edge where cmd_valid_in and cmd_ready_out are both 1, latching the opcode and operand; a command is never accepted while cmd_ready_out is 0.
REQ-017 SHALL move from IDLE to MUL on acceptance of opcode 100, and to EXEC on acceptance of any other opcode.
REQ-018 SHALL, in EXEC, drive alu_a_out = acc, alu_b_out = operand, alu_ctrl_out = ALU_ADD for ADD or ALU_SUB for SUB, then return to IDLE after exactly one cycle.
REQ-019 SHALL, at the end of EXEC for ADD/SUB, capture acc <= alu_sum_in, carry <= alu_carry_in, ovf <= alu_ovf_in, zero <= (alu_sum_in == 0); for SUB, carry = 1 means no borrow.
REQ-020 SHALL, at the end of EXEC for LDA, set acc <= operand, C = 0, V = 0, Z = (operand == 0), without using the ALU result.
REQ-021 SHALL, at the end of EXEC for CLR, set acc = 0, C = 0, V = 0, Z = 1.
REQ-022 SHALL, at the end of EXEC for NOP and illegal opcodes, leave acc and all flags unchanged.
REQ-023 SHALL, for MUL, load on entry mcand = acc, mplier = operand, prod = 0, cnt = 0.
REQ-024 SHALL run exactly 8 MUL cycles, each driving alu_a_out = prod, alu_b_out = mcand, alu_ctrl_out = ALU_ADD.
REQ-025 SHALL, in each MUL cycle, set prod <= alu_sum_in if mplier[0] = 1 and hold prod otherwise, then shift mcand left by 1 and mplier right by 1 (zero fill), and increment cnt.
REQ-026 SHALL, at the end of the 8th MUL cycle, set acc <= low byte of the product, C = 0, V = 0, Z = (result == 0), and return to IDLE.
REQ-027 SHALL, outside EXEC/MUL and for NOP/LDA/CLR/illegal in EXEC, drive alu_a_out = 0, alu_b_out = 0, alu_ctrl_out = ALU_ADD.
REQ-028 SHALL register done_out high for exactly the one cycle after the last EXEC or MUL cycle.
REQ-029 SHALL produce this latency: accept at edge k, then done_out and the new acc/flags in cycle k+2 for non-MUL ops and in cycle k+9 for MUL.
REQ-030 SHALL assert err_out together with done_out, only for opcodes 110/111.
REQ-031 SHALL re-enable acceptance in the done_out cycle, giving a back-to-back non-MUL throughput of one command per 2 cycles.
REQ-032 SHALL ignore cmd_op_in and cmd_data_in changes while EXEC/MUL is in progress.

Reset
REQ-033 SHALL, while rst_in is high at a rising edge, force state IDLE, acc = 0x00, C = V = Z = 0, done_out = 0, err_out = 0, internal MUL registers = 0.
REQ-034 SHALL hold cmd_ready_out at 0 while rst_in is high.
REQ-035 SHALL, on reset during EXEC or MUL, abandon the operation with no done_out and return acc to 0x00.

Verification
REQ-036 SHALL be verified by: LDA 0x7F then ADD 0x01 -> acc 0x80, V=1, C=0, Z=0; done_out 2 cycles after each accept.
REQ-037 SHALL be verified by: LDA 0x05 then SUB 0x05 -> acc 0x00, Z=1, C=1, V=0; then SUB 0x01 -> acc 0xFF, C=0, Z=0.
REQ-038 SHALL be verified by: LDA 0x0D then MUL 0x0B -> acc 0x8F, C=V=Z=0; done_out exactly 9 cycles after accept; cmd_ready_out low throughout.
REQ-039 SHALL be verified by: LDA 0x10 then MUL 0x10 -> acc 0x00, Z=1; rst_in high during the 4th MUL cycle -> acc 0x00, no done_out, ready the cycle after reset is released.
REQ-040 SHALL be verified by: op 111 with data 0x55 after LDA 0x22 -> done_out and err_out pulse together for one cycle, acc stays 0x22, flags unchanged.
REQ-041 SHALL be verified by: cmd_valid_in held high with ADD 0x01 four times from acc 0xFE -> accepts every 2nd cycle, acc 0xFF, 0x00 (C=1, Z=1), 0x01, 0x02.
